// File: rtl/ysyx_23060278_core_seq.sv
// Multi-cycle core sequencer: fetch, execute, optional load/store, write-back.
// Define YSYX_23060278_BUS_TIMEOUT_EN to enable the bus-wait watchdog (err + halt on expiry).
module ysyx_23060278_core_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_ebreak,
   output logic        dmem_req,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   output logic        pc_wen,
   output logic        rf_wen,
   output logic        halt,
   output logic        err,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_IF_REQ  = 3'd1,
      S_IF_WAIT = 3'd2,
      S_EX      = 3'd3,
      S_LS_REQ  = 3'd4,
      S_LS_WAIT = 3'd5,
      S_WB      = 3'd6,
      S_HALT    = 3'd7
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] inst_q, inst_d;

   // Limits outside 1..255 are illegal; this empty marker block makes such a build visible.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_illegal_timeout
   end

`ifdef YSYX_23060278_BUS_TIMEOUT_EN
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wdog_q, wdog_d;
   logic       err_q, err_d;
   logic       in_bus;
`endif

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      unique case (state_q)
         S_IDLE:    state_d = S_IF_REQ;
         S_IF_REQ: begin
            if (imem_gnt && imem_rvalid) begin
               inst_d  = imem_rdata;
               state_d = S_EX;
            end else if (imem_gnt) begin
               state_d = S_IF_WAIT;
            end
         end
         S_IF_WAIT: begin
            if (imem_rvalid) begin
               inst_d  = imem_rdata;
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (is_ebreak)                state_d = S_HALT;
            else if (is_load || is_store) state_d = S_LS_REQ;
            else                          state_d = S_WB;
         end
         S_LS_REQ: begin
            if (dmem_gnt && dmem_rvalid) state_d = S_WB;
            else if (dmem_gnt)           state_d = S_LS_WAIT;
         end
         S_LS_WAIT: begin
            if (dmem_rvalid) state_d = S_WB;
         end
         S_WB:      state_d = S_IF_REQ;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_IDLE;
      endcase

`ifdef YSYX_23060278_BUS_TIMEOUT_EN
      // Bus progress on the final allowed cycle wins over the watchdog.
      wdog_d = '0;
      err_d  = err_q;
      if (in_bus && (state_d == state_q)) begin
         if (wdog_q == WDOG_LAST) begin
            state_d = S_HALT;
            err_d   = 1'b1;
         end else begin
            wdog_d = wdog_q + 8'd1;
         end
      end
`endif
   end

`ifdef YSYX_23060278_BUS_TIMEOUT_EN
   assign in_bus = (state_q == S_IF_REQ) || (state_q == S_IF_WAIT) ||
                   (state_q == S_LS_REQ) || (state_q == S_LS_WAIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
      end
   end

   assign imem_req = (state_q == S_IF_REQ);
   assign dmem_req = (state_q == S_LS_REQ);
   assign pc_wen   = (state_q == S_WB);
   assign rf_wen   = (state_q == S_WB) && !is_store;
   assign halt     = (state_q == S_HALT);
   assign inst     = inst_q;
   assign state    = state_q;

endmodule

// File: tb/tb_ysyx_23060278_core_seq.sv
// Directed bench for ysyx_23060278_core_seq with an instruction-phase model checked every cycle.
module tb_ysyx_23060278_core_seq;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata, inst;
   logic        is_load, is_store, is_ebreak;
   logic        dmem_req, dmem_gnt, dmem_rvalid;
   logic        pc_wen, rf_wen, halt, err;
   logic [2:0]  state;

   int vectors = 0;
   int fails   = 0;
   bit cmp_on  = 1'b0;

   always #5 clk = ~clk;

   ysyx_23060278_core_seq #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst(inst),
      .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak),
      .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .pc_wen(pc_wen), .rf_wen(rf_wen), .halt(halt), .err(err), .state(state)
   );

   // Model: which phase of the current instruction is in progress.
   typedef struct {
      bit          boot;
      bit          fetch;
      bit          fgnt;
      bit          dec;
      bit          mem;
      bit          mgnt;
      bit          wb;
      bit          halted;
      bit          errd;
      logic [31:0] ir;
      int          age;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.boot = 1'b1; r.fetch = 1'b0; r.fgnt = 1'b0; r.dec = 1'b0;
      r.mem = 1'b0;  r.mgnt = 1'b0;  r.wb = 1'b0;   r.halted = 1'b0;
      r.errd = 1'b0; r.ir = '0;      r.age = 0;
      return r;
   endfunction

   function automatic mdl_t mdl_next(input mdl_t c);
      mdl_t n;
      bit waiting, moved;
      n = c;
      waiting = 1'b0;
      moved   = 1'b0;
      if (c.halted) return c;
      if (c.boot) begin
         n.boot = 1'b0; n.fetch = 1'b1; n.fgnt = 1'b0;
      end else if (c.fetch) begin
         waiting = 1'b1;
         if (c.fgnt ? imem_rvalid : (imem_gnt && imem_rvalid)) begin
            n.ir = imem_rdata; n.fetch = 1'b0; n.fgnt = 1'b0; n.dec = 1'b1; moved = 1'b1;
         end else if (!c.fgnt && imem_gnt) begin
            n.fgnt = 1'b1; moved = 1'b1;
         end
      end else if (c.dec) begin
         n.dec = 1'b0;
         if (is_ebreak)                n.halted = 1'b1;
         else if (is_load || is_store) begin n.mem = 1'b1; n.mgnt = 1'b0; end
         else                          n.wb = 1'b1;
      end else if (c.mem) begin
         waiting = 1'b1;
         if (c.mgnt ? dmem_rvalid : (dmem_gnt && dmem_rvalid)) begin
            n.mem = 1'b0; n.mgnt = 1'b0; n.wb = 1'b1; moved = 1'b1;
         end else if (!c.mgnt && dmem_gnt) begin
            n.mgnt = 1'b1; moved = 1'b1;
         end
      end else if (c.wb) begin
         n.wb = 1'b0; n.fetch = 1'b1; n.fgnt = 1'b0;
      end
      n.age = 0;
      if (waiting && !moved) begin
`ifdef YSYX_23060278_BUS_TIMEOUT_EN
         if (c.age == TMO - 1) begin
            n.fetch = 1'b0; n.fgnt = 1'b0; n.mem = 1'b0; n.mgnt = 1'b0;
            n.halted = 1'b1; n.errd = 1'b1;
         end else begin
            n.age = c.age + 1;
         end
`else
         n.age = c.age + 1;
`endif
      end
      return n;
   endfunction

   function automatic logic [2:0] mdl_state(input mdl_t c);
      if (c.halted)   return 3'd7;
      if (c.boot)     return 3'd0;
      if (c.fetch)    return c.fgnt ? 3'd2 : 3'd1;
      if (c.dec)      return 3'd3;
      if (c.mem)      return c.mgnt ? 3'd5 : 3'd4;
      if (c.wb)       return 3'd6;
      return 3'd0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) m <= mdl_reset();
      else      m <= mdl_next(m);
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         logic [8:0] act, exp;
         act = {state, imem_req, dmem_req, pc_wen, rf_wen, halt, err};
         exp = {mdl_state(m), m.fetch && !m.fgnt, m.mem && !m.mgnt,
                m.wb, m.wb && !is_store, m.halted, m.errd};
         vectors = vectors + 1;
         if (act !== exp || inst !== m.ir) begin
            fails = fails + 1;
            $display("FAIL cycle_cmp t=%0t outs=%b inst=%h required outs=%b inst=%h",
                     $time, act, inst, exp, m.ir);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s got=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      is_load = 0; is_store = 0; is_ebreak = 0;
      dmem_gnt = 0; dmem_rvalid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int reqs;
      rst = 1'b0;
      idle_inputs();
      step();
      step();
      cmp_on = 1'b1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outs", {26'd0, imem_req, dmem_req, pc_wen, rf_wen, halt, err}, 32'd0);
      chk("reset_inst", inst, 32'd0);

      // ALU instruction: gnt first cycle, rvalid next.
      rst = 1'b1;
      step();
      chk("idle_to_ifreq", {29'd0, state}, 32'd1);
      chk("ifreq_req", 32'(imem_req), 32'd1);
      imem_gnt = 1;
      step();
      chk("ifwait", {29'd0, state}, 32'd2);
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00100093;
      step();
      chk("alu_ex_inst", inst, 32'h00100093);
      chk("alu_ex_state", {29'd0, state}, 32'd3);
      imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
      step();
      chk("alu_wb_wen", {30'd0, pc_wen, rf_wen}, 32'd3);
      chk("stray_rvalid_ignored", inst, 32'h00100093);
      idle_inputs();
      step();
      chk("wb_to_ifreq", {29'd0, state}, 32'd1);

      // Store: zero-wait fetch, dmem gnt in 4th LS_REQ cycle, rvalid 2 cycles later.
      imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h00112023;
      step();
      idle_inputs();
      is_store = 1;
      step();
      reqs = 0;
      for (int i = 0; i < 4; i++) begin
         if (dmem_req) reqs++;
         dmem_gnt = (i == 3);
         step();
      end
      dmem_gnt = 0;
      chk("store_req_cycles", 32'(reqs), 32'd4);
      chk("store_lswait", {29'd0, state}, 32'd5);
      step();
      dmem_rvalid = 1;
      step();
      dmem_rvalid = 0;
      chk("store_wb", {29'd0, state, pc_wen, rf_wen}, {27'd0, 3'd6, 2'b10});
      step();
      is_store = 0;

      // gnt and rvalid together: IF_WAIT skipped.
      imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h00000013;
      step();
      idle_inputs();
      chk("skip_wait_state", {29'd0, state}, 32'd3);
      chk("skip_wait_inst", inst, 32'h00000013);
      step();
      step();

      // Reset mid-LS_WAIT, late rvalid after release.
      imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h00002083;
      step();
      idle_inputs();
      is_load = 1;
      step();
      dmem_gnt = 1;
      step();
      chk("load_lswait", {29'd0, state}, 32'd5);
      idle_inputs();
      rst = 1'b0;
      #1;
      chk("async_rst", {26'd0, state, imem_req, dmem_req, pc_wen, rf_wen}, 32'd0);
      chk("async_rst_inst", inst, 32'd0);
      step();
      dmem_rvalid = 1;
      rst = 1'b1;
      step();
      dmem_rvalid = 0;
      chk("post_rst_ifreq", {29'd0, state}, 32'd1);

      // ebreak beats load in EX, then HALT absorbs everything.
      imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h00100073;
      step();
      idle_inputs();
      is_ebreak = 1; is_load = 1;
      step();
      chk("halt_state", {29'd0, state}, 32'd7);
      chk("halt_flag", 32'(halt), 32'd1);
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         imem_gnt = i[0]; imem_rvalid = i[1]; imem_rdata = 32'h1000 + 32'(i);
         dmem_gnt = i[2]; dmem_rvalid = ~i[0]; is_store = i[1];
         step();
         if (dmem_req || pc_wen || rf_wen || imem_req || state != 3'd7) reqs++;
      end
      chk("halt_absorb", 32'(reqs), 32'd0);
      chk("halt_inst_frozen", inst, 32'h00100073);

      // Bus watchdog with imem_gnt held low.
      idle_inputs();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
`ifdef YSYX_23060278_BUS_TIMEOUT_EN
      repeat (TMO - 1) step();
      chk("wdog_not_yet", {29'd0, state}, 32'd1);
      step();
      chk("wdog_halt", {29'd0, state, halt, err}, {27'd0, 3'd7, 2'b11});
`else
      repeat (999) step();
      chk("no_wdog_ifreq", {29'd0, state}, 32'd1);
      chk("no_wdog_err", 32'(err), 32'd0);
`endif
      cmp_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/ysyx_23060278_core_seq.md
YSYX_23060278_CORE_SEQ -- requirements
Module: ysyx_23060278_core_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the bus-wait watchdog limit in cycles (8-bit counter; legal 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-004 SHALL have port imem_req  output  1  instruction fetch request; address is the current pc held by the pc register.
REQ-005 SHALL have port imem_gnt  input  1  fetch request accepted.
REQ-006 SHALL have port imem_rvalid  input  1  fetch data valid.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port inst  output  32  latched instruction register, feeding the decoder.
REQ-009 SHALL have port is_load  input  1  decoder: current inst is a load.
REQ-010 SHALL have port is_store  input  1  decoder: current inst is a store.
REQ-011 SHALL have port is_ebreak  input  1  decoder: current inst is ebreak.
REQ-012 SHALL have port dmem_req  output  1  load/store request.
REQ-013 SHALL have port dmem_gnt  input  1  load/store request accepted.
REQ-014 SHALL have port dmem_rvalid  input  1  load data valid or store completed.
REQ-015 SHALL have port pc_wen  output  1  pc register update enable (pc <= dnxt_pc).
REQ-016 SHALL have port rf_wen  output  1  register-file write enable.
REQ-017 SHALL have port halt  output  1  core stopped (sticky).
REQ-018 SHALL have port err  output  1  bus watchdog expired (sticky).
REQ-019 SHALL have port state  output  3  current FSM state encoding, for debug.

Function
REQ-020 SHALL implement states IDLE=0, IF_REQ=1, IF_WAIT=2, EX=3, LS_REQ=4, LS_WAIT=5, WB=6, HALT=7.
REQ-021 SHALL transition IDLE->IF_REQ unconditionally one cycle after reset release.
REQ-022 SHALL assert imem_req only in IF_REQ, held high until imem_gnt; gnt without rvalid -> IF_WAIT.
REQ-023 SHALL, on imem_rvalid in IF_WAIT, or imem_gnt and imem_rvalid together in IF_REQ, latch imem_rdata into inst and go to EX.
REQ-024 SHALL ignore imem_rvalid/dmem_rvalid in every state other than the corresponding REQ/WAIT states.
REQ-025 SHALL, in EX (exactly one cycle), go to HALT if is_ebreak; else LS_REQ if is_load or is_store; else WB. is_ebreak takes priority over is_load/is_store.
REQ-026 SHALL handle LS_REQ/LS_WAIT identically to IF_REQ/IF_WAIT using dmem_req/dmem_gnt/dmem_rvalid, ending in WB.
REQ-027 SHALL, in WB (exactly one cycle), assert pc_wen=1, and rf_wen=1 unless is_store; then go to IF_REQ.
REQ-028 SHALL assert pc_wen and rf_wen in no state other than WB.
REQ-029 SHALL give latency IF_REQ entry -> pc_wen = 4 cycles for a non-memory instruction with gnt in the first IF_REQ cycle and rvalid the next.
REQ-030 SHALL keep HALT absorbing until reset: halt=1, all requests and enables 0, inst frozen.
REQ-031 SHALL drive state output combinationally from the state register.

Reset
REQ-032 SHALL, on rst=0 at any time (including mid-transaction), asynchronously force state=IDLE, inst=0, watchdog=0, halt=0, err=0, and imem_req=dmem_req=pc_wen=rf_wen=0.
REQ-033 SHALL not complete an interrupted bus transaction after reset; a late rvalid is dropped per REQ-024.

Configuration
REQ-034 SHALL, with YSYX_23060278_BUS_TIMEOUT_EN defined, count consecutive cycles spent in IF_REQ, IF_WAIT, LS_REQ or LS_WAIT, clear the count on every state change, and on reaching TIMEOUT_CYCLES enter HALT with err=1 and halt=1.
REQ-035 SHALL, without YSYX_23060278_BUS_TIMEOUT_EN, omit the counter, wait indefinitely in REQ/WAIT states, and tie err to 0.

Verification
REQ-036 ALU inst, gnt in first IF_REQ cycle, rvalid next, rdata=32'h00100093 -> inst=32'h00100093 in EX; pc_wen=1, rf_wen=1 in WB, 4 cycles after IF_REQ entry.
REQ-037 Store, imem zero-wait, dmem gnt after 3 cycles and rvalid 2 cycles later -> dmem_req high 4 cycles; WB pc_wen=1, rf_wen=0.
REQ-038 imem_gnt and imem_rvalid together in IF_REQ, rdata=32'h00000013 -> IF_WAIT skipped; EX next cycle with inst=32'h00000013.
REQ-039 is_ebreak=1 and is_load=1 together in EX -> HALT; halt=1, state=7; no dmem_req or pc_wen for 20 further cycles.
REQ-040 rst=0 mid-LS_WAIT, then dmem_rvalid after release -> immediate state=0, all outputs 0; rvalid ignored; next cycle IF_REQ.
REQ-041 With YSYX_23060278_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, imem_gnt held 0 -> HALT with err=1 after 16 IF_REQ cycles; without the macro -> still IF_REQ at 1000 cycles, err=0.
